// File: rtl/boot_loader_pkg.sv
// Shared types and default sizing for the boot loader.
package boot_loader_pkg;

  localparam int LOAD_COUNT_DFLT = 128;
  localparam int ADDR_W_DFLT     = 8;
  localparam int DATA_W_DFLT     = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_port_mux.sv
// Combinational data-memory port select: CPU request when idle, loader while it owns the port.
module mem_port_mux #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_ldr_own,
  input  logic [ADDR_W-1:0] i_ldr_address,
  input  logic [DATA_W-1:0] i_ldr_data,
  input  logic              i_ldr_write,
  input  logic [ADDR_W-1:0] i_cpu_address,
  input  logic [DATA_W-1:0] i_cpu_data,
  input  logic              i_cpu_write,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_write
);

  // CPU writes during a load are dropped, not deferred.
  assign o_mem_address = i_ldr_own ? i_ldr_address : i_cpu_address;
  assign o_mem_data    = i_ldr_own ? i_ldr_data    : i_cpu_data;
  assign o_mem_write   = i_ldr_own ? i_ldr_write   : i_cpu_write;

endmodule

// File: rtl/boot_loader.sv
// Copies LOAD_COUNT bytes from a file reader into data memory, 3 cycles per byte.
// Define BOOT_CHECKSUM_EN to accumulate a modulo-2^DATA_W checksum of the written bytes.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int LOAD_COUNT = LOAD_COUNT_DFLT,
  parameter int ADDR_W     = ADDR_W_DFLT,
  parameter int DATA_W     = DATA_W_DFLT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              fr_read,
  input  logic [DATA_W-1:0] fr_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data_in,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_data_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  // Terminal compare avoids any wrap of the index at LOAD_COUNT = 2^ADDR_W.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LOAD_COUNT - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_index;
  logic [DATA_W-1:0] r_byte;
  logic              r_fr_read;
  logic              r_busy;
  logic              r_done;
  logic              w_ldr_write;
  logic              w_start_ok;

  assign w_ldr_write = (r_state == WRITE);
  assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_index   <= '0;
      r_byte    <= '0;
      r_fr_read <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state   <= READ;
            r_index   <= '0;
            r_fr_read <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        READ: begin
          r_state   <= CAPTURE;
          r_fr_read <= 1'b0;
        end
        CAPTURE: begin
          r_byte  <= fr_data;
          r_state <= WRITE;
        end
        WRITE: begin
          if (r_index == LAST_IDX) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_index   <= r_index + 1'b1;
            r_state   <= READ;
            r_fr_read <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_fr_read <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clock) begin
    if (reset || w_start_ok) begin
      r_checksum <= '0;
    end else if (w_ldr_write) begin
      r_checksum <= r_checksum + r_byte;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  mem_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_port_mux (
    .i_ldr_own     (r_busy),
    .i_ldr_address (r_index),
    .i_ldr_data    (r_byte),
    .i_ldr_write   (w_ldr_write),
    .i_cpu_address (cpu_address),
    .i_cpu_data    (cpu_data_in),
    .i_cpu_write   (cpu_write),
    .o_mem_address (mem_address),
    .o_mem_data    (mem_data_in),
    .o_mem_write   (mem_write)
  );

  assign cpu_data_out = mem_data_out;
  assign fr_read      = r_fr_read;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench: instance A uses LOAD_COUNT=128, instance B uses LOAD_COUNT=256.
module tb_boot_loader;

`ifdef BOOT_CHECKSUM_EN
  localparam logic [7:0] CS_A = 8'h40;
  localparam logic [7:0] CS_B = 8'h80;
`else
  localparam logic [7:0] CS_A = 8'h00;
  localparam logic [7:0] CS_B = 8'h00;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Instance A signals and models
  logic       reset_a, start_a, fr_read_a, mem_write_a, cpu_write_a, busy_a, done_a, clr_a;
  logic [7:0] fr_data_a, mem_address_a, mem_data_in_a, mem_data_out_a;
  logic [7:0] cpu_address_a, cpu_data_in_a, cpu_data_out_a, checksum_a;
  logic [7:0] ram_a [256];
  int         rd_a;

  assign mem_data_out_a = ram_a[mem_address_a];

  always @(posedge clock) begin
    if (clr_a) begin
      for (int i = 0; i < 256; i++) ram_a[i] <= 8'hEE;
      rd_a      <= 0;
      fr_data_a <= 8'h00;
    end else begin
      if (mem_write_a) ram_a[mem_address_a] <= mem_data_in_a;
      if (fr_read_a) begin
        fr_data_a <= 8'(rd_a + 1);
        rd_a      <= rd_a + 1;
      end
    end
  end

  boot_loader #(.LOAD_COUNT(128), .ADDR_W(8), .DATA_W(8)) u_dut_a (
    .clock(clock), .reset(reset_a), .start(start_a),
    .fr_read(fr_read_a), .fr_data(fr_data_a),
    .mem_address(mem_address_a), .mem_data_in(mem_data_in_a), .mem_write(mem_write_a),
    .mem_data_out(mem_data_out_a),
    .cpu_address(cpu_address_a), .cpu_data_in(cpu_data_in_a), .cpu_write(cpu_write_a),
    .cpu_data_out(cpu_data_out_a),
    .busy(busy_a), .done(done_a), .checksum(checksum_a)
  );

  // Instance B signals and models
  logic       reset_b, start_b, fr_read_b, mem_write_b, cpu_write_b, busy_b, done_b, clr_b;
  logic [7:0] fr_data_b, mem_address_b, mem_data_in_b, mem_data_out_b;
  logic [7:0] cpu_address_b, cpu_data_in_b, cpu_data_out_b, checksum_b;
  logic [7:0] ram_b [256];
  int         rd_b, wr_cnt_b, bad_addr_b;

  assign mem_data_out_b = ram_b[mem_address_b];

  always @(posedge clock) begin
    if (clr_b) begin
      for (int i = 0; i < 256; i++) ram_b[i] <= 8'hEE;
      rd_b       <= 0;
      wr_cnt_b   <= 0;
      bad_addr_b <= 0;
      fr_data_b  <= 8'h00;
    end else begin
      if (mem_write_b) begin
        ram_b[mem_address_b] <= mem_data_in_b;
        if (int'(mem_address_b) != wr_cnt_b) bad_addr_b <= bad_addr_b + 1;
        wr_cnt_b <= wr_cnt_b + 1;
      end
      if (fr_read_b) begin
        fr_data_b <= 8'(rd_b + 1);
        rd_b      <= rd_b + 1;
      end
    end
  end

  boot_loader #(.LOAD_COUNT(256), .ADDR_W(8), .DATA_W(8)) u_dut_b (
    .clock(clock), .reset(reset_b), .start(start_b),
    .fr_read(fr_read_b), .fr_data(fr_data_b),
    .mem_address(mem_address_b), .mem_data_in(mem_data_in_b), .mem_write(mem_write_b),
    .mem_data_out(mem_data_out_b),
    .cpu_address(cpu_address_b), .cpu_data_in(cpu_data_in_b), .cpu_write(cpu_write_b),
    .cpu_data_out(cpu_data_out_b),
    .busy(busy_b), .done(done_b), .checksum(checksum_b)
  );

  int lat;
  int bad;
  logic found;
  logic pulsed;

  initial begin
    clr_a = 1'b1; clr_b = 1'b1; reset_a = 1'b1; reset_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    cpu_write_a = 1'b0; cpu_address_a = 8'h00; cpu_data_in_a = 8'h00;
    cpu_write_b = 1'b0; cpu_address_b = 8'h00; cpu_data_in_b = 8'h00;
    repeat (3) @(negedge clock);
    clr_a = 1'b0; clr_b = 1'b0;

    // Reset state and idle pass-through
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_fr_read", fr_read_a, 1'b0);
    check("rst_checksum", checksum_a, 8'h00);
    reset_a = 1'b0;
    cpu_address_a = 8'h33;
    #1 check("idle_addr_pass", mem_address_a, 8'h33);
    check("idle_write_pass", mem_write_a, 1'b0);

    // Start coinciding with a CPU write; the CPU write lands, then loader owns port
    @(negedge clock);
    start_a = 1'b1; cpu_write_a = 1'b1; cpu_address_a = 8'd200; cpu_data_in_a = 8'h77;
    @(negedge clock);
    start_a = 1'b0; cpu_address_a = 8'd5; cpu_data_in_a = 8'hAA;
    check("load_busy", busy_a, 1'b1);
    check("load_fr_read", fr_read_a, 1'b1);
    check("load_cpu_dropped", mem_write_a, 1'b0);
    check("load_addr_index", mem_address_a, 8'h00);
    lat = 1;
    while (!done_a && lat < 2000) begin
      @(negedge clock);
      if (!done_a) lat++;
      if (lat == 100) cpu_write_a = 1'b0;
    end
    check("latency_a", lat, 384);
    check("done_a", done_a, 1'b1);
    check("done_busy_a", busy_a, 1'b0);
    check("done_fr_read_a", fr_read_a, 1'b0);
    check("reads_a", rd_a, 128);
    bad = 0;
    for (int k = 0; k < 128; k++) if (ram_a[k] !== 8'(k + 1)) bad++;
    check("ram_contents_a", bad, 0);
    check("ram5_loaded", ram_a[5], 8'h06);
    check("ram200_cpu", ram_a[200], 8'h77);
    check("checksum_a", checksum_a, CS_A);

    // CPU access after load
    cpu_address_a = 8'd9; cpu_data_in_a = 8'h3C; cpu_write_a = 1'b1;
    @(negedge clock);
    cpu_write_a = 1'b0;
    #1 check("ram9_cpu", ram_a[9], 8'h3C);
    check("cpu_readback", cpu_data_out_a, 8'h3C);
    check("done_sticky", done_a, 1'b1);

    // Restart from DONE, abort with reset at index 50
    clr_a = 1'b1;
    @(negedge clock);
    clr_a = 1'b0; start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clock);
      if (busy_a && fr_read_a && mem_address_a == 8'd50) found = 1'b1;
    end
    check("abort_reached", found, 1'b1);
    reset_a = 1'b1;
    @(negedge clock);
    check("abort_busy", busy_a, 1'b0);
    check("abort_done", done_a, 1'b0);
    check("abort_fr_read", fr_read_a, 1'b0);
    check("abort_checksum", checksum_a, 8'h00);
    reset_a = 1'b0;
    repeat (5) @(negedge clock);
    bad = 0;
    for (int k = 50; k < 128; k++) if (ram_a[k] !== 8'hEE) bad++;
    check("abort_unwritten", bad, 0);
    check("abort_ram49", ram_a[49], 8'd50);

    // LOAD_COUNT=256 with a start pulse mid-load that must be ignored
    reset_b = 1'b0;
    @(negedge clock);
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    lat = 1;
    pulsed = 1'b0;
    while (!done_b && lat < 3000) begin
      @(negedge clock);
      if (!done_b) lat++;
      if (!pulsed && busy_b && mem_address_b == 8'd10) begin
        start_b = 1'b1;
        pulsed = 1'b1;
      end else begin
        start_b = 1'b0;
      end
    end
    start_b = 1'b0;
    check("pulse_issued_b", pulsed, 1'b1);
    check("latency_b", lat, 768);
    check("done_b", done_b, 1'b1);
    check("writes_b", wr_cnt_b, 256);
    check("write_addr_seq_b", bad_addr_b, 0);
    check("reads_b", rd_b, 256);
    check("ram_b0", ram_b[0], 8'h01);
    check("ram_b10", ram_b[10], 8'h0B);
    check("ram_b255", ram_b[255], 8'h00);
    check("checksum_b", checksum_b, CS_B);
    cpu_address_b = 8'd0;
    #1 check("cpu_readback_b", cpu_data_out_b, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 The block SHALL have parameter LOAD_COUNT, default 128, giving the number of bytes loaded (legal 1..256).
REQ-002 The block SHALL have parameter ADDR_W, default 8, giving the memory address width.
REQ-003 The block SHALL have parameter DATA_W, default 8, giving the data width.
REQ-004 The block SHALL have port clock  in  1  sole clock, rising edge.
REQ-005 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port start  in  1  one-cycle load request.
REQ-007 The block SHALL have port fr_read  out  1  read strobe to the file reader.
REQ-008 The block SHALL have port fr_data  in  DATA_W  file reader byte, valid the cycle after fr_read.
REQ-009 The block SHALL have ports mem_address  out  ADDR_W, mem_data_in  out  DATA_W and mem_write  out  1, forming the data memory port.
REQ-010 The block SHALL have port mem_data_out  in  DATA_W  memory read data.
REQ-011 The block SHALL have ports cpu_address  in  ADDR_W, cpu_data_in  in  DATA_W and cpu_write  in  1, forming the processor request.
REQ-012 The block SHALL have port cpu_data_out  out  DATA_W, which is mem_data_out passed through unconditionally.
REQ-013 The block SHALL have ports busy  out  1  load in progress, done  out  1  load complete (sticky) and checksum  out  DATA_W.

Function
REQ-014 The FSM SHALL have the states IDLE, READ, CAPTURE, WRITE and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL clear the index and checksum and go to READ; start in any other state SHALL be ignored.
REQ-016 READ SHALL assert fr_read for exactly one cycle and then go to CAPTURE.
REQ-017 CAPTURE SHALL latch fr_data into the byte register and then go to WRITE.
REQ-018 WRITE SHALL drive mem_write=1, mem_address=index and mem_data_in=byte register for one cycle.
REQ-019 From WRITE, the FSM SHALL go to DONE if index==LOAD_COUNT-1; otherwise it SHALL increment the index and go to READ.
REQ-020 Load latency SHALL be exactly 3*LOAD_COUNT cycles from the cycle after start to the first DONE cycle.
REQ-021 The index SHALL be ADDR_W bits wide and SHALL never wrap during a load, including at LOAD_COUNT=256.
REQ-022 busy SHALL be 1 in READ, CAPTURE and WRITE, and 0 in IDLE and DONE.
REQ-023 done SHALL be 1 only in DONE.
REQ-024 Arbitration: in IDLE and DONE, mem_address, mem_data_in and mem_write SHALL equal the cpu_* inputs combinationally.
REQ-025 While busy=1, the block SHALL own the memory port, cpu_write SHALL be dropped with no queueing, and mem_address SHALL be the index.
REQ-026 While busy=1, mem_write SHALL be 0 outside WRITE.
REQ-027 A start that coincides with cpu_write in IDLE or DONE SHALL let the CPU write complete that cycle, with the loader taking the port from the next cycle.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE, index=0, byte register=0 and checksum=0, giving fr_read=0, busy=0 and done=0 on the next cycle.
REQ-029 Reset SHALL take precedence over start.
REQ-030 Reset mid-load SHALL abort the load with no further loader write; bytes already written stay in memory.

Configuration
REQ-031 With BOOT_CHECKSUM_EN defined, checksum SHALL accumulate the modulo-2^DATA_W sum of every byte written in WRITE.
REQ-032 With BOOT_CHECKSUM_EN defined, checksum SHALL be held in DONE and cleared on start.
REQ-033 Without BOOT_CHECKSUM_EN, checksum SHALL be tied to 0 and no accumulator SHALL be synthesised.

Structure
REQ-034 Package boot_loader_pkg SHALL hold the state enum and the default constants LOAD_COUNT, ADDR_W and DATA_W.
REQ-035 Sub-module mem_port_mux SHALL implement the combinational CPU/loader port select; FSM, index and checksum SHALL stay in boot_loader.

Verification
REQ-036 The bench SHALL cover: reset, then start with a file reader supplying byte k=k+1 -> 384 cycles later done=1 and RAM[0..127]=1..128.
REQ-037 The bench SHALL cover: with BOOT_CHECKSUM_EN and the same stimulus -> checksum=8'h40 (sum 1..128 mod 256).
REQ-038 The bench SHALL cover: cpu_write=1, cpu_address=5, cpu_data_in=8'hAA during the load -> RAM[5] holds the loaded byte 6, not 8'hAA.
REQ-039 The bench SHALL cover: after done, cpu_write to address 9 with 8'h3C -> RAM[9]=8'h3C, and cpu_data_out reads back 8'h3C.
REQ-040 The bench SHALL cover: reset asserted at index 50 -> next cycle busy=0, done=0, fr_read=0, and RAM[50..127] unwritten.
REQ-041 The bench SHALL cover: start pulsed at index 10, then LOAD_COUNT=256 -> the pulse is ignored, and exactly 256 writes occur, at addresses 0..255.
